// File: rtl/fofb_cc_crc_framer.sv
// rtl/fofb_cc_crc_framer.sv - frames a payload stream with the external CRC engine's two result words
// Payload words pass through a one-deep output register; the CRC hi/lo words follow after end of frame.
module fofb_cc_crc_framer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        s_ready,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  input  logic        m_ready,
  output logic [15:0] crc_d,
  output logic        crc_calc,
  output logic        crc_d_valid,
  output logic        crc_init,
  input  logic [15:0] crc_word,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic        sof_err
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO} state_t;

  state_t      state, state_nxt;
  logic        ofree;
  logic        take;
  logic        load;
  logic [15:0] load_data;
  logic        load_sof;
  logic        load_eof;
  logic        drop;
  logic        frame_done;
  logic        sof_err_nxt;

  assign ofree = ~m_valid | m_ready;
  assign take  = s_valid & ofree;

  // Everything is gated by reset so no strobe can reach the engine while it is being reset.
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    load        = 1'b0;
    load_data   = s_data;
    load_sof    = 1'b0;
    load_eof    = 1'b0;
    crc_d       = s_data;
    crc_calc    = 1'b0;
    crc_d_valid = 1'b0;
    crc_init    = 1'b0;
    drop        = 1'b0;
    frame_done  = 1'b0;
    sof_err_nxt = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          s_ready = ofree;
          if (take) begin
            if (s_sof) begin
              load        = 1'b1;
              load_sof    = 1'b1;
              crc_d_valid = 1'b1;
              crc_calc    = 1'b1;
              state_nxt   = s_eof ? CRC_HI : PAYLOAD;
            end else begin
              drop = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          s_ready = ofree;
          if (take) begin
            load        = 1'b1;
            crc_d_valid = 1'b1;
            crc_calc    = 1'b1;
            sof_err_nxt = s_sof;
            if (s_eof) state_nxt = CRC_HI;
          end
        end
        CRC_HI: begin
          // Shift strobe moves the engine's low half up for the CRC_LO word.
          if (ofree) begin
            load        = 1'b1;
            load_data   = crc_word;
            crc_d_valid = 1'b1;
            state_nxt   = CRC_LO;
          end
        end
        CRC_LO: begin
          if (ofree) begin
            load       = 1'b1;
            load_data  = crc_word;
            load_eof   = 1'b1;
            crc_init   = 1'b1;
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      m_valid     <= 1'b0;
      m_data      <= 16'h0000;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      sof_err     <= 1'b0;
      frame_count <= 16'h0000;
      drop_count  <= 8'h00;
    end else begin
      state   <= state_nxt;
      sof_err <= sof_err_nxt;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_sof   <= load_sof;
        m_eof   <= load_eof;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: doc/fofb_cc_crc_framer.md
FOFB_CC_CRC_FRAMER -- requirements
Module: fofb_cc_crc_framer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset; one clock, async active-high reset.
REQ-003 SHALL have ports s_data [15:0] input, s_valid input, s_sof input, s_eof input (payload stream in) and s_ready output.
REQ-004 SHALL have ports m_data [15:0], m_valid, m_sof, m_eof, all outputs (framed stream out), and m_ready input.
REQ-005 SHALL have CRC-engine drive outputs crc_d [15:0], crc_calc, crc_d_valid, crc_init, each 1 bit except crc_d.
REQ-006 SHALL have CRC-engine result input crc_word [15:0]: registered, complemented, bit-swapped CRC word, updated the edge after a crc_d_valid or crc_init strobe.
REQ-007 SHALL have outputs frame_count [15:0] (frames completed) and drop_count [7:0] (words dropped outside a frame), plus sof_err, 1-bit pulse.

Function
REQ-008 SHALL implement FSM states IDLE, PAYLOAD, CRC_HI, CRC_LO.
REQ-009 Output register free (ofree) SHALL be ~m_valid | m_ready; m_valid SHALL clear on m_ready when nothing new is loaded.
REQ-010 s_ready SHALL equal ofree in IDLE and PAYLOAD, and 0 in CRC_HI/CRC_LO; accept = s_valid & s_ready.
REQ-011 IDLE: an accepted word with s_sof=0 SHALL be dropped (no m_ output, no CRC strobe), drop_count +1, saturating at 255.
REQ-012 IDLE: an accepted word with s_sof=1 SHALL be loaded into m_ (m_sof=1, m_eof=0), next state PAYLOAD, or CRC_HI if s_eof=1 too.
REQ-013 PAYLOAD: accepted words SHALL load into m_ with m_sof=0, m_eof=0; s_eof=1 SHALL move to CRC_HI.
REQ-014 PAYLOAD: s_sof=1 SHALL be treated as data and pulse sof_err for one cycle.
REQ-015 Every payload word accepted in IDLE (with sof) or PAYLOAD SHALL, in the same cycle, drive crc_d_valid=1, crc_calc=1, crc_d=s_data.
REQ-016 Payload latency SHALL be one cycle: a word accepted at edge n is on m_data after edge n.
REQ-017 CRC_HI: when ofree, m_data SHALL load crc_word (m_sof=0, m_eof=0), crc_d_valid=1 and crc_calc=0 (engine shift) SHALL be driven that cycle, next state CRC_LO; otherwise hold with no strobe.
REQ-018 CRC_LO: when ofree, m_data SHALL load crc_word with m_eof=1, crc_init=1 SHALL pulse that cycle, frame_count +1 (wrapping 0xFFFF->0), next state IDLE.
REQ-019 crc_calc, crc_d_valid and crc_init SHALL be 0 in every cycle not named in REQ-015/017/018; crc_init and crc_d_valid SHALL never be 1 together.
REQ-020 An N-word frame SHALL produce exactly N+2 output words; with m_ready held high, frames SHALL stream back-to-back with no idle cycle.
REQ-021 Backpressure (m_ready=0) SHALL never lose, duplicate or reorder a word; crc strobes SHALL occur only on load cycles.

Reset
REQ-022 Reset SHALL force state IDLE, m_valid=0, m_data=0, m_sof=0, m_eof=0, sof_err=0, frame_count=0, drop_count=0; strobes SHALL be 0 during reset.
REQ-023 Reset mid-frame SHALL discard the partial frame; the engine relies on its own reset to 0xFFFFFFFF, so no crc_init SHALL be issued on exit from reset.

Verification
REQ-024 Single-word frame 0x0000 (sof=eof=1), m_ready=1 -> m: 0x0000 (sof), CRC hi, CRC lo (eof) on three consecutive cycles; CRC matches engine model; frame_count=1.
REQ-025 4-word frame 0x0001..0x0004 with m_ready toggling 1,0 -> output 0x0001..0x0004, CRC hi, CRC lo in order; exactly 4 calc strobes, 1 shift strobe, 1 init strobe.
REQ-026 Three words without sof in IDLE, then 300 more -> no m_valid, drop_count 3 then saturates at 255.
REQ-027 sof reasserted on word 2 of a 3-word frame -> sof_err pulses once; frame emitted as 5 words with correct CRC.
REQ-028 Reset asserted after 2 of 4 words accepted, then a 1-word frame -> only the new frame appears, CRC equals the single-word reference value, frame_count=1.
